// File: rtl/pna_pkg.sv
// pna_pkg: shared sample type and shot-buffer state encoding for the phase-noise path
package pna_pkg;
    typedef logic signed [15:0] sample_t;
    typedef enum logic [1:0] {SB_IDLE, SB_CAPTURE, SB_PLAY} shot_state_t;
endpackage

// File: rtl/shot_ram.sv
// shot_ram: simple dual-port sample RAM, one write port and a registered read port (1-cycle latency)
module shot_ram
    import pna_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  sample_t                  wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output sample_t                  rd_data
);
    sample_t mem [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/shot_buffer.sv
// shot_buffer: captures DEPTH decimated samples on a shot edge and replays them slowly, live passthrough otherwise.
// Define SHOT_LOOP_EN to replay continuously and allow re-arming from PLAY.
module shot_buffer
    import pna_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int PLAY_DIV = 200
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    tick_i,
    input  logic    shot_i,
    input  sample_t signal_i,
    output sample_t signal_o,
    output logic    capture_o,
    output logic    play_o,
    output logic    done_o
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DIV_W  = $clog2(PLAY_DIV + 1);
`ifdef SHOT_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    shot_state_t       state;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DIV_W-1:0]  div_cnt;
    logic              shot_q, last_q, upd_q, sel_q;
    sample_t           pass_q, rd_data;
    logic              shot_edge, read_due, pass_end, rearm, rd_en, we, live;

    assign shot_edge = shot_i & ~shot_q;
    assign read_due  = state == SB_PLAY && tick_i && div_cnt == '0;
    assign pass_end  = read_due && last_q;
    assign rearm     = LOOP && state == SB_PLAY && shot_edge;
    assign rd_en     = read_due && !rearm && (LOOP || !last_q);
    assign we        = state == SB_CAPTURE && tick_i;
    // every tick that does not fetch a stored sample outside PLAY's hold window goes live
    assign live      = tick_i && (state != SB_PLAY || rearm || (read_due && !rd_en));

    shot_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (clk_i),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (signal_i),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= SB_IDLE;
            wr_addr   <= '0;
            rd_addr   <= '0;
            div_cnt   <= '0;
            shot_q    <= 1'b0;
            last_q    <= 1'b0;
            upd_q     <= 1'b0;
            sel_q     <= 1'b0;
            pass_q    <= '0;
            signal_o  <= '0;
            capture_o <= 1'b0;
            play_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            shot_q <= shot_i;
            upd_q  <= rd_en || live;
            sel_q  <= rd_en;
            done_o <= pass_end && !rearm;
            if (live) pass_q <= signal_i;
            if (upd_q) signal_o <= sel_q ? rd_data : pass_q;
            if (we) wr_addr <= wr_addr + 1'b1;
            if (tick_i && state == SB_PLAY)
                div_cnt <= div_cnt == DIV_W'(PLAY_DIV - 1) ? '0 : div_cnt + 1'b1;
            if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
                last_q  <= rd_addr == ADDR_W'(DEPTH - 1);
            end
            case (state)
                SB_IDLE: if (shot_edge) begin
                    state     <= SB_CAPTURE;
                    wr_addr   <= '0;
                    capture_o <= 1'b1;
                end
                SB_CAPTURE: if (we && wr_addr == ADDR_W'(DEPTH - 1)) begin
                    state     <= SB_PLAY;
                    rd_addr   <= '0;
                    div_cnt   <= '0;
                    last_q    <= 1'b0;
                    capture_o <= 1'b0;
                    play_o    <= 1'b1;
                end
                SB_PLAY: if (rearm) begin
                    state     <= SB_CAPTURE;
                    wr_addr   <= '0;
                    capture_o <= 1'b1;
                    play_o    <= 1'b0;
                end else if (pass_end && !LOOP) begin
                    state  <= SB_IDLE;
                    play_o <= 1'b0;
                end
                default: begin
                    state     <= SB_IDLE;
                    capture_o <= 1'b0;
                    play_o    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/shot_buffer.md
# shot_buffer

Single-shot capture-and-replay buffer between the phase low-pass FIR and the output-select mux that feeds the CIC interpolator. On a shot trigger it records `DEPTH` consecutive filtered-phase samples at the decimated rate (200 kHz), then replays them slowly, one sample per `PLAY_DIV` decimated ticks. A brief phase-noise event therefore becomes visible on a slow scope through the DAC. When idle, it passes the live signal through with the same latency.

## Interface
- `DEPTH`, 1024: samples per shot; power of two, ≥ 2; `ADDR_W = $clog2(DEPTH)`.
- `PLAY_DIV`, 200: decimated ticks each replayed sample is held; ≥ 1.
- `clk_i`  in  1  system clock (50 MHz).
- `rst_i`  in  1  reset; synchronous, active-high.
- `tick_i`  in  1  decimated-rate strobe, one `clk_i` cycle wide.
- `shot_i`  in  1  trigger level, already synchronous to `clk_i`; acts on its rising edge.
- `signal_i`  in  16  signed filtered phase.
- `signal_o`  out  16  signed live or replayed sample.
- `capture_o`  out  1  high in CAPTURE.
- `play_o`  out  1  high in PLAY.
- `done_o`  out  1  one-cycle pulse when a replay pass completes.

## Operation
- **Reset.** State goes to IDLE, all counters are cleared, and the `shot_i` edge register clears. All outputs are 0, including `signal_o`. RAM contents are not cleared.
- **Edge detect.** `shot_edge = shot_i & ~shot_q`.
- **IDLE.**
  - Each `tick_i` forwards `signal_i` to `signal_o`.
  - `shot_edge` → CAPTURE, with `wr_addr = 0`.
  - A tick in the same cycle as the edge is forwarded but not captured.
- **CAPTURE.**
  - Each `tick_i` writes `signal_i` to `RAM[wr_addr]` and increments `wr_addr`; the live passthrough continues.
  - The tick that writes `DEPTH-1` → PLAY, with `rd_addr = 0` and `div_cnt = 0`.
  - `shot_edge` is ignored.
- **PLAY.**
  - On each `tick_i` with `div_cnt == 0`, read `RAM[rd_addr]` and latch it to `signal_o`.
  - `div_cnt` counts modulo `PLAY_DIV` on every tick. Sample k is therefore held for exactly `PLAY_DIV` ticks.
  - When `div_cnt` wraps after the `DEPTH-1` sample, on the tick where the next read would be due:
    - pulse `done_o`;
    - → IDLE;
    - the same tick is forwarded live.
- **Arithmetic.** No arithmetic is applied to samples; they are stored bit-exact.
  - `wr_addr`/`rd_addr` are `ADDR_W` bits and wrap naturally.
  - `div_cnt` is `$clog2(PLAY_DIV+1)` bits.
- **Reset mid-operation.** Aborts immediately to IDLE, with no `done_o` pulse.

## Timing
- `signal_o` updates exactly 2 `clk_i` cycles after the qualifying `tick_i` in every state:
  - cycle 1: RAM read, or passthrough pipeline register;
  - cycle 2: output register.
- Between updates, `signal_o` holds its value.
- A state change takes effect in the cycle after the triggering tick or edge.
- `capture_o`/`play_o` are registered state decodes, valid from that same cycle.
- `done_o` is asserted in the cycle after the final PLAY tick, coincident with `play_o` falling.
- `tick_i` spacing is ≥ 3 cycles (250 in system), so pipeline stages never overlap.

## Configuration
- `SHOT_LOOP_EN`
  - **Defined:** at the end of a pass, `done_o` pulses, `rd_addr` wraps to 0, and PLAY continues indefinitely. `shot_edge` in PLAY → CAPTURE (re-arm), and live passthrough resumes on the next tick.
  - **Undefined:** a single pass runs, then → IDLE. `shot_edge` in PLAY is ignored.

## Structure
- Shared package `pna_pkg` holds:
  - `typedef logic signed [15:0] sample_t`;
  - `typedef enum logic [1:0] {SB_IDLE, SB_CAPTURE, SB_PLAY} shot_state_t`.
- Sub-module `shot_ram`: simple dual-port inferred RAM (`DEPTH` × 16, one write port, one registered read port, 1-cycle latency), mapping to M9K.
- The FSM, counters and output pipeline live in `shot_buffer`.

## Test plan
- **Reset.** Hold `rst_i` 3 cycles with `signal_i = 16'h7FFF` and ticks running → `signal_o = 0`, `capture_o = play_o = done_o = 0`.
- **Passthrough.** IDLE, `signal_i = 1234`, tick at cycle t → `signal_o = 1234` at t+2, unchanged until the next tick.
- **Capture/replay** (`DEPTH = 8`, `PLAY_DIV = 3`, tick every 5 cycles).
  - Stimulus: `shot_i` rises, then ramp `signal_i` = −4..3 on 8 ticks.
  - Response: `capture_o` high for 8 ticks; each of −4..3 held on `signal_o` for 3 ticks (24 total); `done_o` one-cycle pulse after the 24th tick; back to live.
- **Ignored shot.** Second `shot_i` edge mid-CAPTURE → capture count and replay unchanged.
- **Abort.** `rst_i` at replay sample 5 → IDLE next cycle, `signal_o = 0`, no `done_o`; a new shot captures correctly.
- **`SHOT_LOOP_EN` defined.** Same as the capture/replay case → `done_o` every 24 ticks, sequence repeats −4..3. A `shot_i` edge during PLAY → `capture_o` rises and a new ramp 10..17 replays.
